// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  function automatic logic is_div(muldiv_op_e op);
    return op >= DIV;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational RADIX-bit slice, shift-add multiply or restoring divide
module muldiv_step #(
  parameter int XLEN  = 32,
  parameter int RADIX = 1
) (
  input  logic            div_i,
  input  logic [XLEN:0]   acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   acc_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0]   acc_w [RADIX+1];
  logic [XLEN-1:0] lo_w  [RADIX+1];
  assign acc_w[0] = acc_i;
  assign lo_w[0]  = lo_i;
  for (genvar i = 0; i < RADIX; i++) begin : g_bit
    logic [XLEN:0]   sum, sh;
    logic [XLEN+1:0] dif;
    // multiply: {acc,lo} is the product, multiplier bits consumed from lo[0]
    assign sum = acc_w[i] + (lo_w[i][0] ? {1'b0, opnd_i} : '0);
    // divide: acc is the partial remainder, dividend bits enter from lo msb
    assign sh  = {acc_w[i][XLEN-1:0], lo_w[i][XLEN-1]};
    assign dif = {1'b0, sh} - {2'b0, opnd_i};
    assign acc_w[i+1] = div_i ? (dif[XLEN+1] ? sh : dif[XLEN:0]) : {1'b0, sum[XLEN:1]};
    assign lo_w[i+1]  = div_i ? {lo_w[i][XLEN-2:0], ~dif[XLEN+1]} : {sum[0], lo_w[i][XLEN-1:1]};
  end
  assign acc_o = acc_w[RADIX];
  assign lo_o  = lo_w[RADIX];
endmodule

// File: rtl/muldiv_iterative_unit.sv
// muldiv_iterative_unit: iterative RV32M/RV64M execute unit, all M ops behind start/done
module muldiv_iterative_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADIX = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int N  = XLEN / RADIX;
  localparam int CW = $clog2(N);
  state_e          state_q;
  muldiv_op_e      op_q, op;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d, opnd_q, result_q, a_mag, b_mag, sp_res, quo, rem, res_d;
  logic [2*XLEN-1:0] prod;
  logic            neg_q, nrem_q, a_sgn, b_sgn, rem_op, special;
  assign op      = muldiv_op_e'(op_i);
  assign a_sgn   = (op == MULH || op == MULHSU || op == DIV || op == REM) && src_a_i[XLEN-1];
  assign b_sgn   = (op == MULH || op == DIV || op == REM) && src_b_i[XLEN-1];
  assign a_mag   = a_sgn ? -src_a_i : src_a_i;
  assign b_mag   = b_sgn ? -src_b_i : src_b_i;
  assign rem_op  = op == REM || op == REMU;
  // divide-by-zero and signed overflow skip the datapath entirely
  assign special = is_div(op) && (~|src_b_i || ((op == DIV || op == REM) &&
                   src_a_i == {1'b1, {(XLEN-1){1'b0}}} && &src_b_i));
  assign sp_res  = ~|src_b_i ? (rem_op ? src_a_i : '1) : (rem_op ? '0 : src_a_i);
  muldiv_step #(.XLEN(XLEN), .RADIX(RADIX)) u_step (
    .div_i (is_div(op_q)),
    .acc_i (acc_q),
    .lo_i  (lo_q),
    .opnd_i(opnd_q),
    .acc_o (acc_d),
    .lo_o  (lo_d)
  );
  assign prod  = neg_q ? -{acc_q[XLEN-1:0], lo_q} : {acc_q[XLEN-1:0], lo_q};
  assign quo   = neg_q ? -lo_q : lo_q;
  assign rem   = nrem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign res_d = is_div(op_q) ? ((op_q == REM || op_q == REMU) ? rem : quo) :
                 (op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      nrem_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end
        end
        FIX: begin
          result_q <= res_d;
          state_q  <= DONE;
        end
        default: begin
          state_q <= IDLE;
          if (start_i) begin
            state_q <= special ? DONE : CALC;
            cnt_q   <= '0;
            op_q    <= op;
            neg_q   <= a_sgn ^ b_sgn;
            nrem_q  <= a_sgn;
            acc_q   <= '0;
            lo_q    <= is_div(op) ? a_mag : b_mag;
            opnd_q  <= is_div(op) ? b_mag : a_mag;
            if (special) result_q <= sp_res;
          end
        end
      endcase
    end
  end
  assign ready_o  = state_q == IDLE || state_q == DONE;
  assign busy_o   = state_q == CALC || state_q == FIX;
  assign done_o   = state_q == DONE;
  assign result_o = result_q;
endmodule
